// File: rtl/pe_feeder.sv
// Sequencer for one dot-product PE: buffers column B[*,j], issues row jobs,
// streams the column beat by beat and returns the PE result on a valid/ready port.
module pe_feeder #(
  parameter int P           = 8,
  parameter int DATA_WIDTH  = 16,
  parameter int ACCUM_WIDTH = 2*DATA_WIDTH,
  parameter int TIMEOUT     = P+8,
  localparam int AW         = (P > 1) ? $clog2(P) : 1,
  localparam int WW         = $clog2(TIMEOUT+1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    col_wr_en,
  input  logic [AW-1:0]           col_wr_addr,
  input  logic [DATA_WIDTH-1:0]   col_wr_data,
  output logic                    col_wr_ready,
  input  logic                    job_valid,
  output logic                    job_ready,
  input  logic [P*DATA_WIDTH-1:0] job_row,
  output logic                    pe_load_row,
  output logic                    pe_start,
  output logic [P*DATA_WIDTH-1:0] pe_row,
  output logic [DATA_WIDTH-1:0]   pe_col_entry,
  input  logic                    pe_done,
  input  logic                    pe_err,
  input  logic [ACCUM_WIDTH-1:0]  pe_total,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [ACCUM_WIDTH-1:0]  res_total,
  output logic                    res_err,
  output logic                    res_timeout
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_STREAM, S_WAIT, S_OUT} state_t;

  state_t                  state_reg, state_next;
  logic [AW-1:0]           beat_reg;
  logic [WW-1:0]           wait_reg;
  logic                    err_reg;
  logic [DATA_WIDTH-1:0]   colbuf_reg [P];
  logic [P*DATA_WIDTH-1:0] row_reg;
  logic [ACCUM_WIDTH-1:0]  total_reg;
  logic                    res_err_reg;
  logic                    timeout_reg;
  logic                    last_beat;
  logic                    wait_expired;

  assign last_beat    = (beat_reg == AW'(P-1));
  assign wait_expired = (wait_reg == WW'(TIMEOUT-1));

  assign job_ready    = (state_reg == S_IDLE);
  assign col_wr_ready = (state_reg == S_IDLE) || (state_reg == S_OUT);
  assign pe_load_row  = (state_reg == S_ISSUE);
  assign pe_start     = (state_reg == S_ISSUE);
  assign res_valid    = (state_reg == S_OUT);
  assign pe_row       = row_reg;
  assign res_total    = total_reg;
  assign res_err      = res_err_reg;
  assign res_timeout  = timeout_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next   = state_reg;
    pe_col_entry = '0;
    case (state_reg)
      S_IDLE:   if (job_valid) state_next = S_ISSUE;
      S_ISSUE:  state_next = S_STREAM;
      S_STREAM: begin
        pe_col_entry = colbuf_reg[beat_reg];
        if (last_beat) state_next = S_WAIT;
      end
      S_WAIT: begin
        // Hold the final beat on the bus while the PE finishes.
        pe_col_entry = colbuf_reg[P-1];
        if (pe_done || wait_expired) state_next = S_OUT;
      end
      S_OUT:    if (res_ready) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Column buffer is only writable while no job is using it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < P; k++) colbuf_reg[k] <= '0;
    end else if (col_wr_en && col_wr_ready) begin
      colbuf_reg[col_wr_addr] <= col_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_reg     <= '0;
      beat_reg    <= '0;
      wait_reg    <= '0;
      err_reg     <= 1'b0;
      total_reg   <= '0;
      res_err_reg <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: if (job_valid) row_reg <= job_row;
        S_ISSUE: begin
          beat_reg <= '0;
          wait_reg <= '0;
          err_reg  <= 1'b0;
        end
        S_STREAM: begin
          beat_reg <= beat_reg + 1'b1;
          wait_reg <= '0;
          if (pe_err) err_reg <= 1'b1;
        end
        S_WAIT: begin
          wait_reg <= wait_reg + 1'b1;
          if (pe_err) err_reg <= 1'b1;
          // A done arriving on the last allowed cycle still counts as success.
          if (pe_done || wait_expired) begin
            total_reg   <= pe_done ? pe_total : '0;
            res_err_reg <= err_reg | pe_err;
            timeout_reg <= ~pe_done;
          end
        end
        S_OUT: if (res_ready) begin
          total_reg   <= '0;
          res_err_reg <= 1'b0;
          timeout_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_feeder.sv
// Self-checking bench for pe_feeder: behavioural PE plus a column/row reference model.
module tb_pe_feeder;
  localparam int P  = 4;
  localparam int DW = 16;
  localparam int AW = 2;
  localparam int TO = P + 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            col_wr_en = 1'b0;
  logic [AW-1:0]   col_wr_addr = '0;
  logic [DW-1:0]   col_wr_data = '0;
  logic            col_wr_ready;
  logic            job_valid = 1'b0;
  logic            job_ready;
  logic [P*DW-1:0] job_row = '0;
  logic            pe_load_row, pe_start;
  logic [P*DW-1:0] pe_row;
  logic [DW-1:0]   pe_col_entry;
  logic            pe_done;
  logic            pe_err = 1'b0;
  logic [2*DW-1:0] pe_total;
  logic            res_valid;
  logic            res_ready = 1'b0;
  logic [2*DW-1:0] res_total;
  logic            res_err, res_timeout;

  pe_feeder #(.P(P), .DATA_WIDTH(DW), .ACCUM_WIDTH(2*DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .col_wr_en(col_wr_en), .col_wr_addr(col_wr_addr), .col_wr_data(col_wr_data),
    .col_wr_ready(col_wr_ready),
    .job_valid(job_valid), .job_ready(job_ready), .job_row(job_row),
    .pe_load_row(pe_load_row), .pe_start(pe_start), .pe_row(pe_row),
    .pe_col_entry(pe_col_entry), .pe_done(pe_done), .pe_err(pe_err), .pe_total(pe_total),
    .res_valid(res_valid), .res_ready(res_ready), .res_total(res_total),
    .res_err(res_err), .res_timeout(res_timeout)
  );

  always #5 clk = ~clk;

  function automatic int sx(input logic [DW-1:0] v);
    return int'($signed(v));
  endfunction

  // Behavioural PE: start clears it, then it consumes P beats and raises done a cycle later.
  bit pe_hang = 1'b0;
  int pe_k, pe_acc;
  bit pe_active, pe_done_q;
  assign pe_done  = pe_done_q;
  assign pe_total = pe_acc;
  always @(posedge clk) begin
    if (!rst_n) begin
      pe_k <= 0; pe_acc <= 0; pe_active <= 1'b0; pe_done_q <= 1'b0;
    end else if (pe_start) begin
      pe_k <= 0; pe_acc <= 0; pe_active <= 1'b1; pe_done_q <= 1'b0;
    end else if (pe_active) begin
      if (pe_k < P) begin
        pe_acc <= pe_acc + sx(pe_row[pe_k*DW +: DW]) * sx(pe_col_entry);
        pe_k   <= pe_k + 1;
      end else begin
        pe_active <= 1'b0;
        if (!pe_hang) pe_done_q <= 1'b1;
      end
    end
  end

  int mdl_col [P];
  int n_checks = 0;
  int n_fail   = 0;
  int n_jobs   = 0;

  function automatic logic [P*DW-1:0] pack4(input int a, input int b, input int c, input int d);
    logic [P*DW-1:0] r;
    r = {DW'(d), DW'(c), DW'(b), DW'(a)};
    return r;
  endfunction

  task automatic col_write(input int addr, input int data);
    col_wr_en = 1'b1; col_wr_addr = AW'(addr); col_wr_data = DW'(data);
    @(negedge clk);
    col_wr_en = 1'b0;
    mdl_col[addr] = sx(DW'(data));
  endtask

  task automatic run_job(input logic [P*DW-1:0] row, input int hold, input bit stream_wr,
                         input bit out_wr, input bit inj_err, input bit hang);
    longint exp_sum;
    logic [2*DW-1:0] exp_total, held_total;
    int n, exp_lat, exp_beat;
    bit seen;
    exp_sum = 0;
    for (int k = 0; k < P; k++) exp_sum += longint'(sx(row[k*DW +: DW])) * mdl_col[k];
    exp_total = hang ? '0 : (2*DW)'(exp_sum);
    exp_lat   = hang ? 1 + P + TO : P + 3;
    pe_hang   = hang;
    n_checks++;
    if (job_ready !== 1'b1) begin n_fail++; $display("FAIL job_ready_idle: got %b want 1", job_ready); end
    job_valid = 1'b1; job_row = row;
    @(negedge clk);
    job_valid = 1'b0; job_row = {$urandom, $urandom};
    n_checks++;
    if ({pe_load_row, pe_start, job_ready} !== 3'b110 || pe_row !== row) begin
      n_fail++;
      $display("FAIL issue: load/start/ready=%b pe_row=%h want 110 %h", {pe_load_row, pe_start, job_ready}, pe_row, row);
    end
    n = 0; seen = 1'b0;
    while (!seen && n < 60) begin
      @(negedge clk); n++;
      col_wr_en = 1'b0;
      if (stream_wr && n == 1) begin
        n_checks++;
        if (col_wr_ready !== 1'b0) begin n_fail++; $display("FAIL col_wr_ready_stream: got %b want 0", col_wr_ready); end
        col_wr_en = 1'b1; col_wr_addr = '0; col_wr_data = DW'(99);
      end
      pe_err = inj_err && (n == 2);
      if (res_valid) seen = 1'b1;
      else begin
        exp_beat = (n <= P) ? mdl_col[n-1] : mdl_col[P-1];
        n_checks++;
        if (pe_col_entry !== DW'(exp_beat) || pe_start !== 1'b0 || pe_load_row !== 1'b0) begin
          n_fail++;
          $display("FAIL beat%0d: col_entry=%0d start=%b load=%b want %0d 0 0", n, sx(pe_col_entry), pe_start, pe_load_row, exp_beat);
        end
      end
    end
    pe_err = 1'b0; col_wr_en = 1'b0;
    n_checks++;
    if (!seen || n != exp_lat) begin n_fail++; $display("FAIL latency: got %0d edges (seen=%b) want %0d", n, seen, exp_lat); end
    n_checks++;
    if (res_total !== exp_total || res_err !== inj_err || res_timeout !== hang || pe_col_entry !== '0) begin
      n_fail++;
      $display("FAIL result: total=%0d err=%b to=%b col=%0d want %0d %b %b 0",
               $signed(res_total), res_err, res_timeout, pe_col_entry, $signed(exp_total), inj_err, hang);
    end
    held_total = res_total;
    for (int i = 0; i < hold; i++) begin
      col_wr_en = out_wr && (i == 0);
      col_wr_addr = '0; col_wr_data = DW'(99);
      @(negedge clk);
      n_checks++;
      if (res_valid !== 1'b1 || res_total !== held_total || job_ready !== 1'b0 || col_wr_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL hold%0d: valid=%b total=%0d ready=%b colrdy=%b want 1 %0d 0 1", i, res_valid, $signed(res_total), job_ready, col_wr_ready, $signed(held_total));
      end
    end
    col_wr_en = 1'b0;
    if (out_wr && hold > 0) mdl_col[0] = 99;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    n_checks++;
    if (res_valid !== 1'b0 || job_ready !== 1'b1 || res_timeout !== 1'b0 || res_err !== 1'b0) begin
      n_fail++;
      $display("FAIL handshake: valid=%b ready=%b to=%b err=%b want 0 1 0 0", res_valid, job_ready, res_timeout, res_err);
    end
    n_jobs++;
    $display("job %0d: row=%h total=%0d err=%b timeout=%b latency=%0d", n_jobs, row, $signed(exp_total), inj_err, hang, n);
  endtask

  task automatic check_idle_zero(input string tag);
    n_checks++;
    if (pe_load_row !== 0 || pe_start !== 0 || pe_row !== '0 || pe_col_entry !== '0 || res_valid !== 0 ||
        res_total !== '0 || res_err !== 0 || res_timeout !== 0 || job_ready !== 1 || col_wr_ready !== 1) begin
      n_fail++;
      $display("FAIL %s: load=%b start=%b row=%h col=%h valid=%b total=%h err=%b to=%b jr=%b cr=%b want zeros with jr=cr=1",
               tag, pe_load_row, pe_start, pe_row, pe_col_entry, res_valid, res_total, res_err, res_timeout, job_ready, col_wr_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_zero("after_reset");
    for (int k = 0; k < P; k++) mdl_col[k] = 0;
  endtask

  task automatic test_basic();
    col_write(0, 5); col_write(1, 6); col_write(2, 7); col_write(3, 8);
    run_job(pack4(1, 2, 3, 4), 0, 0, 0, 0, 0);
  endtask

  task automatic test_signed();
    col_write(0, -3); col_write(1, 2); col_write(2, 0); col_write(3, 1);
    run_job(pack4(4, -5, 9, -2), 0, 0, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    run_job(pack4(7, -1, 3, 100), 5, 0, 0, 0, 0);
    run_job(pack4(-8, 2, 2, 2), 1, 0, 0, 0, 0);
  endtask

  task automatic test_col_write_timing();
    col_write(0, 11);
    run_job(pack4(1, 0, 0, 0), 2, 1, 0, 0, 0);
    run_job(pack4(1, 0, 0, 0), 2, 0, 1, 0, 0);
    run_job(pack4(1, 1, 0, 0), 0, 0, 0, 0, 0);
  endtask

  task automatic test_err();
    run_job(pack4(3, 3, 3, 3), 0, 0, 0, 1, 0);
    run_job(pack4(3, 3, 3, 3), 0, 0, 0, 0, 0);
  endtask

  task automatic test_timeout();
    run_job(pack4(9, 9, 9, 9), 2, 0, 0, 0, 1);
    run_job(pack4(2, 4, 6, 8), 0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    int a;
    for (int j = 0; j < 8; j++) begin
      for (int k = 0; k < P; k++) col_write(k, $urandom_range(2000) - 1000);
      a = $urandom_range(P-1);
      col_write(a, $urandom_range(2000) - 1000);
      run_job(pack4($urandom_range(2000) - 1000, $urandom_range(2000) - 1000,
                    $urandom_range(2000) - 1000, $urandom_range(2000) - 1000),
              $urandom_range(3), 0, 0, 0, 0);
    end
  endtask

  task automatic test_reset_mid_stream();
    col_write(0, 21); col_write(1, -22); col_write(2, 23); col_write(3, 24);
    job_valid = 1'b1; job_row = pack4(1, 2, 3, 4);
    @(negedge clk);
    job_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_idle_zero("mid_stream_reset");
    for (int k = 0; k < P; k++) mdl_col[k] = 0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (res_valid !== 1'b0) begin n_fail++; $display("FAIL aborted_job_result: valid=%b want 0", res_valid); end
    run_job(pack4(5, 6, 7, 8), 0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_back_to_back();
    test_col_write_timing();
    test_err();
    test_timeout();
    test_random();
    test_reset_mid_stream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
